// File: rtl/run_sequencer.sv
// ---------------------------------------------------------------------------
// run_sequencer
//   Run-control state machine IDLE -> START -> RUNNING -> STOP with a fixed
//   start-up delay, a run length latched when a run is accepted, pause (hold),
//   abort and back-to-back restart out of STOP.
//
// Ports
//   CLK      in   clock, all state changes on the rising edge
//   RST      in   asynchronous active-low reset
//   go       in   start request, sampled only in IDLE and STOP
//   abort    in   cancel the current run (ignored in IDLE)
//   hold     in   pause RUNNING progress
//   run_len  in   run length in RUNNING cycles, latched on an accepted go
//   state    out  registered state, IDLE=0 START=1 RUNNING=2 STOP=3
//   count    out  RUNNING cycles completed in the current run
//   busy     out  state != IDLE
//   done     out  high exactly while state == STOP
//   aborted  out  one-cycle registered pulse after an abort is taken
//
// Handshake: go is a level request, not a valid/ready pair. It is accepted on
// any rising edge where the FSM is in IDLE (and abort is low) or in STOP; in
// every other state it is ignored, so a controller may simply hold go high to
// chain runs. done is the completion indication and lasts exactly one cycle.
// ---------------------------------------------------------------------------
module run_sequencer #(
  parameter int STATE_W      = 3,
  parameter int CNT_W        = 8,
  parameter int START_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               go,
  input  logic               abort,
  input  logic               hold,
  input  logic [CNT_W-1:0]   run_len,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_RUNNING = 2'd2,
    S_STOP    = 2'd3
  } state_t;

  // Start counter only needs to reach START_CYCLES-1.
  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0] START_LAST = SC_W'(START_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [SC_W-1:0]  start_cnt_q, start_cnt_d;
  logic             aborted_q, aborted_d;

  logic [CNT_W-1:0] count_inc;
  logic [1:0]       state_bits;

  // count never exceeds len-1 while RUNNING, so the increment cannot wrap.
  assign count_inc = count_q + CNT_W'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      len_q       <= '0;
      start_cnt_q <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      start_cnt_q <= start_cnt_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    start_cnt_d = start_cnt_q;
    aborted_d   = 1'b0;

    // Abort outranks every transition; in IDLE it is a no-op and also masks go.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      count_d   = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go && !abort) begin
            state_d     = S_START;
            len_d       = run_len;
            count_d     = '0;
            start_cnt_d = '0;
          end
        end
        S_START: begin
          // hold has no effect on the start-up delay.
          if (start_cnt_q == START_LAST) begin
            state_d = (len_q != '0) ? S_RUNNING : S_STOP;
          end else begin
            start_cnt_d = start_cnt_q + SC_W'(1);
          end
        end
        S_RUNNING: begin
          if (!hold) begin
            count_d = count_inc;
            if (count_inc == len_q) begin
              state_d = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (go) begin
            state_d     = S_START;
            len_d       = run_len;
            count_d     = '0;
            start_cnt_d = '0;
          end else begin
            // count keeps the final value until the next run starts.
            state_d = S_IDLE;
          end
        end
        // Unreachable with a 2-bit encoding today; kept so a widened
        // encoding recovers to IDLE without a done/aborted pulse.
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state_bits = state_q;
  assign state      = STATE_W'(state_bits);
  assign count      = count_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_STOP);
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_run_sequencer
//   Directed bench for run_sequencer (STATE_W=3, CNT_W=8, START_CYCLES=2).
//   Inputs are driven 1 time unit after a rising edge and outputs are checked
//   at the same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_run_sequencer;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;
  localparam int START_C = 2;

  // ---------------- clock / reset ----------------
  logic               CLK;
  logic               RST;
  logic               go;
  logic               abort;
  logic               hold;
  logic [CNT_W-1:0]   run_len;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   count;
  logic               busy;
  logic               done;
  logic               aborted;

  int n_checks;
  int n_fail;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  run_sequencer #(
    .STATE_W      (STATE_W),
    .CNT_W        (CNT_W),
    .START_CYCLES (START_C)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .go      (go),
    .abort   (abort),
    .hold    (hold),
    .run_len (run_len),
    .state   (state),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [CNT_W-1:0] len);
    run_len = len;
    go      = 1'b1;
    tick();
    go      = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  // Expected state/count after each edge of a nominal len=5 run, go sampled at edge 0.
  logic [STATE_W-1:0] exp_q[$];
  logic [CNT_W-1:0]   exp_cnt_q[$];

  initial begin
    logic [STATE_W-1:0] exp_s;
    logic [CNT_W-1:0]   exp_c;
    logic [CNT_W-1:0]   prev_c;
    int run_cycles;
    int budget;
    logic saw_done;
    logic wrapped;

    n_checks = 0;
    n_fail   = 0;
    go       = 1'b0;
    abort    = 1'b0;
    hold     = 1'b0;
    run_len  = '0;
    RST      = 1'b0;

    // ---- reset state ----
    #12;
    check_eq("reset_state",   32'(state),   32'd0);
    check_eq("reset_count",   32'(count),   32'd0);
    check_eq("reset_busy",    32'(busy),    32'd0);
    check_eq("reset_done",    32'(done),    32'd0);
    check_eq("reset_aborted", 32'(aborted), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    check_eq("post_reset_idle", 32'(state), 32'd0);

    // ---- nominal len=5 ----
    exp_q     = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0};
    exp_cnt_q = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5};
    run_len = 8'd5;
    go      = 1'b1;
    while (exp_q.size() != 0) begin
      tick();
      go    = 1'b0;
      exp_s = exp_q.pop_front();
      exp_c = exp_cnt_q.pop_front();
      check_eq("nom_state", 32'(state), 32'(exp_s));
      check_eq("nom_count", 32'(count), 32'(exp_c));
      check_eq("nom_done",  32'(done),  (exp_s == 3'd3) ? 32'd1 : 32'd0);
      check_eq("nom_busy",  32'(busy),  (exp_s != 3'd0) ? 32'd1 : 32'd0);
    end

    // ---- hold for 3 RUNNING cycles ----
    start_run(8'd5);
    run_cycles = 0;
    budget     = 0;
    while (state != 3'd3 && budget < 40) begin
      if (state == 3'd2) run_cycles++;
      hold   = (state == 3'd2) && (run_cycles >= 2) && (run_cycles <= 4);
      prev_c = count;
      tick();
      budget++;
      if (hold) check_eq("hold_count_frozen", 32'(count), 32'(prev_c));
      hold = 1'b0;
    end
    check_eq("hold_reached_stop", 32'(state), 32'd3);
    check_eq("hold_run_cycles",   32'(run_cycles), 32'd8);
    check_eq("hold_final_count",  32'(count), 32'd5);
    tick();
    check_eq("hold_back_idle", 32'(state), 32'd0);

    // ---- abort in 3rd RUNNING cycle ----
    saw_done = 1'b0;
    start_run(8'd5);
    tick();
    tick();   // 1st RUNNING cycle
    check_eq("abort_running1", 32'(state), 32'd2);
    tick();   // 2nd
    tick();   // 3rd
    check_eq("abort_running3_count", 32'(count), 32'd2);
    if (done) saw_done = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done) saw_done = 1'b1;
    check_eq("abort_state",   32'(state),   32'd0);
    check_eq("abort_pulse",   32'(aborted), 32'd1);
    check_eq("abort_count",   32'(count),   32'd0);
    tick();
    if (done) saw_done = 1'b1;
    check_eq("abort_pulse_end", 32'(aborted), 32'd0);
    check_eq("abort_no_done",   32'(saw_done), 32'd0);

    // ---- abort in IDLE is ignored and masks go ----
    abort   = 1'b1;
    go      = 1'b1;
    run_len = 8'd3;
    tick();
    abort = 1'b0;
    go    = 1'b0;
    check_eq("idle_abort_state", 32'(state),   32'd0);
    check_eq("idle_abort_pulse", 32'(aborted), 32'd0);

    // ---- restart with go held, second run zero length ----
    run_len = 8'd5;
    go      = 1'b1;
    budget  = 0;
    while (state != 3'd3 && budget < 20) begin
      tick();
      budget++;
    end
    check_eq("rst_first_stop",  32'(state), 32'd3);
    check_eq("rst_first_count", 32'(count), 32'd5);
    run_len = 8'd0;
    tick();
    check_eq("rst_restart_start", 32'(state), 32'd1);
    check_eq("rst_restart_count", 32'(count), 32'd0);
    tick();
    check_eq("rst_start2", 32'(state), 32'd1);
    tick();
    check_eq("rst_zero_stop",  32'(state), 32'd3);
    check_eq("rst_zero_count", 32'(count), 32'd0);
    check_eq("rst_zero_done",  32'(done),  32'd1);
    go = 1'b0;
    tick();
    check_eq("rst_back_idle", 32'(state), 32'd0);

    // ---- max length with mid-run run_len change ----
    start_run(8'd255);
    run_len    = 8'd3;
    run_cycles = 0;
    budget     = 0;
    wrapped    = 1'b0;
    prev_c     = count;
    while (state != 3'd3 && budget < 400) begin
      if (state == 3'd2) run_cycles++;
      tick();
      budget++;
      if (count < prev_c) wrapped = 1'b1;
      prev_c = count;
    end
    check_eq("max_reached_stop", 32'(state),      32'd3);
    check_eq("max_run_cycles",   32'(run_cycles), 32'd255);
    check_eq("max_count",        32'(count),      32'd255);
    check_eq("max_no_wrap",      32'(wrapped),    32'd0);
    tick();
    check_eq("max_back_idle",  32'(state), 32'd0);
    check_eq("max_count_held", 32'(count), 32'd255);

    // ---- async reset mid-RUNNING ----
    start_run(8'd5);
    tick();
    tick();
    tick();
    check_eq("arst_pre_running", 32'(state), 32'd2);
    RST = 1'b0;
    #2;
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_busy",  32'(busy),  32'd0);
    check_eq("arst_done",  32'(done),  32'd0);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    check_eq("arst_idle_after", 32'(state), 32'd0);

    // ---- final report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
